// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side end of the CPU's byte-serial RAM bus.
// A byte-addressed RAM with a registered read port, plus an IO window at and
// above IO_BASE. IO_BASE holds a byte FIFO that feeds the UART transmitter,
// and IO_BASE+4 sets a sticky halt flag.
// Optional feature: define MEM_BOUNDS_CHECK_EN to fault on RAM-space accesses
// beyond 2**ADDR_WIDTH. Without it, those addresses alias into the RAM.
module ram_io_responder #(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        io_overflow,
    output logic        io_halt,
    output logic        mem_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_C   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [31:0]      IO_TX_ADDR = IO_BASE;
    localparam logic [31:0]      IO_HALT_A  = IO_BASE + 32'd4;

    // Address decode
    logic                  is_io;
    logic                  oob;
    logic [ADDR_WIDTH-1:0] idx;

    assign is_io = (mem_a >= IO_BASE);
    assign idx   = mem_a[ADDR_WIDTH-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    // RAM-space address that lies beyond the physical RAM
    assign oob = !is_io && ((mem_a >> ADDR_WIDTH) != 32'd0);
`else
    // Out-of-range addresses are truncated and alias into the RAM
    assign oob = 1'b0;
`endif

    logic ram_wr_en;
    logic ram_rd_en;
    logic push_req;
    logic halt_req;

    assign ram_wr_en = rdy && mem_wr && !is_io && !oob;
    assign ram_rd_en = rdy && !mem_wr;
    assign push_req  = rdy && mem_wr && (mem_a == IO_TX_ADDR);
    assign halt_req  = rdy && mem_wr && (mem_a == IO_HALT_A);

    logic [7:0] ram [2**ADDR_WIDTH];

    // RAM write port
    // NOTE: RAM contents have no reset; clearing a large array would force it out of block memory.
    always_ff @(posedge clk) begin
        if (ram_wr_en) ram[idx] <= mem_dout;
    end

    // Registered read data: RAM byte, zero for IO, all-ones for a bounds fault
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_din <= 8'h00;
        end else if (ram_rd_en) begin
            if (is_io)    mem_din <= 8'h00;
            else if (oob) mem_din <= 8'hFF;
            else          mem_din <= ram[idx];
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // Sticky bounds fault, set by any out-of-range RAM-space access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            mem_fault <= 1'b0;
        else if (rdy && oob) mem_fault <= 1'b1;
    end
`else
    assign mem_fault = 1'b0;
`endif

    // IO byte FIFO
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] count_nxt;

    assign io_tx_valid    = (count != '0);
    assign io_tx_data     = fifo[head];
    assign io_buffer_full = (count >= ALMOST_C);
    assign pop            = io_tx_valid && io_tx_ready;

    // Push acceptance and next occupancy; a pop frees the slot a full-FIFO push needs
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        count_nxt = count;
        if (push_req) begin
            if ((count < DEPTH_C) || pop) push = 1'b1;
            else                          drop = 1'b1;
        end
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (pop && !push) count_nxt = count - 1'b1;
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= mem_dout;
    end

    // FIFO pointers and occupancy; pointers wrap modulo FIFO_DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count_nxt;
        end
    end

    // Sticky overflow and halt flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_overflow <= 1'b0;
            io_halt     <= 1'b0;
        end else begin
            if (drop)     io_overflow <= 1'b1;
            if (halt_req) io_halt     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder. Read data and UART bytes are
// predicted when stimulus is driven, queued, and compared when the DUT
// produces them. The bounds-check case follows MEM_BOUNDS_CHECK_EN.
module tb_ram_io_responder;

    localparam int          AW    = 17;
    localparam logic [31:0] IOB   = 32'h0003_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic        io_overflow;
    logic        io_halt;
    logic        mem_fault;

    ram_io_responder #(.ADDR_WIDTH(AW), .IO_BASE(IOB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .io_tx_data(io_tx_data),
        .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
        .io_overflow(io_overflow), .io_halt(io_halt), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mdl [int];
    logic       exp_ovf;
    logic       exp_halt;
    logic       exp_fault;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_status();
        check("tx_valid", io_tx_valid, tx_q.size() != 0);
        check("buf_full", io_buffer_full, tx_q.size() >= DEPTH - 1);
        check("overflow", io_overflow, exp_ovf);
        check("halt", io_halt, exp_halt);
        check("fault", mem_fault, exp_fault);
    endtask

    // One bus cycle: predict, clock, compare
    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        logic       pop;
        logic       in_ram;
        logic       oob;
        logic [7:0] rexp;
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
        pop = (tx_q.size() != 0) && io_tx_ready;
        if (pop) check("tx_data", io_tx_data, tx_q[0]);
        in_ram = (a < IOB);
`ifdef MEM_BOUNDS_CHECK_EN
        oob = in_ram && (a >= (32'd1 << AW));
`else
        oob = 1'b0;
`endif
        if (rdy) begin
            if (oob) exp_fault = 1'b1;
            if (w) begin
                if (in_ram && !oob) mdl[int'(a & ((32'd1 << AW) - 1))] = d;
                else if (a == IOB) begin
                    if (tx_q.size() < DEPTH || pop) tx_q.push_back(d);
                    else exp_ovf = 1'b1;
                end else if (a == IOB + 32'd4) exp_halt = 1'b1;
            end else begin
                if (!in_ram)  rexp = 8'h00;
                else if (oob) rexp = 8'hFF;
                else          rexp = mdl[int'(a & ((32'd1 << AW) - 1))];
                rd_q.push_back(rexp);
            end
        end
        @(posedge clk);
        #1;
        if (pop) void'(tx_q.pop_front());
        if (rdy && !w) check("rd_data", mem_din, rd_q.pop_front());
        check_status();
    endtask

    task automatic idle();
        bus(IOB + 32'd8, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; mem_a = IOB + 32'd8; mem_wr = 1'b0; mem_dout = 8'h00;
        io_tx_ready = 1'b0; exp_ovf = 1'b0; exp_halt = 1'b0; exp_fault = 1'b0;
        #12;
        check("rst_din", mem_din, 8'h00);
        check_status();
        @(negedge clk) rst = 1'b1;

        // Write then read back on the next cycle
        bus(32'h100, 1'b1, 8'hAB);
        bus(32'h100, 1'b0, 8'h00);

        // Pipelined reads of consecutive addresses
        bus(32'h0, 1'b1, 8'h13);
        for (int i = 1; i < 4; i++) bus(i, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) bus(i, 1'b0, 8'h00);

        // Address just past the RAM: aliases to index 0, or faults with bounds checking
        bus(32'h0002_0000, 1'b1, 8'h5A);
        bus(32'h0, 1'b0, 8'h00);
        bus(32'h0002_0000, 1'b0, 8'h00);

        // Two bytes queued while the UART stalls, then drained in order
        bus(IOB, 1'b1, 8'h48);
        bus(IOB, 1'b1, 8'h69);
        check("tx_head", io_tx_data, 8'h48);
        io_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) idle();

        // Fill past capacity: the ninth byte is dropped
        io_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus(IOB, 1'b1, 8'h80 + 8'(i));
        check("full_after_9", io_buffer_full, 1'b1);
        // Push and pop together on a full FIFO keeps occupancy at capacity
        io_tx_ready = 1'b1;
        bus(IOB, 1'b1, 8'hC0);
        check("cnt_stays_full", tx_q.size(), DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) idle();

        // rdy=0 blocks a RAM write and holds mem_din
        bus(32'h100, 1'b0, 8'h00);
        rdy = 1'b0;
        bus(32'h100, 1'b1, 8'h11);
        bus(32'h0, 1'b0, 8'h00);
        check("din_hold", mem_din, 8'hAB);
        rdy = 1'b1;
        bus(32'h100, 1'b0, 8'h00);

        // Halt flag, other IO writes ignored
        bus(IOB + 32'd8, 1'b1, 8'h77);
        bus(IOB + 32'd4, 1'b1, 8'h01);
        idle();
        idle();

        // Reset while the FIFO is draining
        io_tx_ready = 1'b0;
        bus(IOB, 1'b1, 8'h31);
        bus(IOB, 1'b1, 8'h32);
        io_tx_ready = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tx_q.delete();
        rd_q.delete();
        exp_ovf = 1'b0; exp_halt = 1'b0; exp_fault = 1'b0;
        check("rst_mid_valid", io_tx_valid, 1'b0);
        check("rst_mid_din", mem_din, 8'h00);
        check_status();
        @(negedge clk) rst = 1'b1;
        io_tx_ready = 1'b0;
        idle();
        bus(32'h100, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
